// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits.
// Each cycle it can hold, shift right, shift left or parallel-load, with
// optional rotate and a synchronous clear. A saturating fill counter tracks
// how many stages hold shifted-in data. Every output decodes a register.
module univ_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic [1:0]             mode,
  input  logic                   rot,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [DEPTH*WIDTH-1:0] pin,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [WIDTH-1:0]       so_r,
  output logic [WIDTH-1:0]       so_l,
  output logic [CW-1:0]          count,
  output logic                   full
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] r_stage      [DEPTH];
  logic [WIDTH-1:0] w_stage_next [DEPTH];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic [CW-1:0]    w_count_inc;
  logic [WIDTH-1:0] w_in_r;
  logic [WIDTH-1:0] w_in_l;

  // Rotate feeds the stage falling off the far end back in place of the serial input.
  assign w_in_r = rot ? r_stage[0]       : sin_r;
  assign w_in_l = rot ? r_stage[DEPTH-1] : sin_l;

  // Fill counter saturates at DEPTH; shifting while full discards the outgoing stage.
  assign w_count_inc = (r_count == COUNT_MAX) ? r_count : r_count + CW'(1);

  // Next-state selection: clear beats every mode, rotate leaves the count alone.
  always_comb begin
    w_count_next = r_count;
    for (int i = 0; i < DEPTH; i++) begin
      w_stage_next[i] = r_stage[i];
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_stage_next[i] = '0;
      end
      w_count_next = '0;
    end else begin
      case (mode)
        MODE_SHR: begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            w_stage_next[i] = r_stage[i+1];
          end
          w_stage_next[DEPTH-1] = w_in_r;
          if (!rot) begin
            w_count_next = w_count_inc;
          end
        end
        MODE_SHL: begin
          for (int i = 1; i < DEPTH; i++) begin
            w_stage_next[i] = r_stage[i-1];
          end
          w_stage_next[0] = w_in_l;
          if (!rot) begin
            w_count_next = w_count_inc;
          end
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            w_stage_next[i] = pin[i*WIDTH +: WIDTH];
          end
          w_count_next = COUNT_MAX;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  // State registers; reset clears everything immediately, without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '{default: '0};
      r_count <= '0;
    end else begin
      r_stage <= w_stage_next;
      r_count <= w_count_next;
    end
  end

  // Flatten the stage array onto the parallel output, stage i at slice i.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pout
    assign pout[gi*WIDTH +: WIDTH] = r_stage[gi];
  end

  assign so_r  = r_stage[0];
  assign so_l  = r_stage[DEPTH-1];
  assign count = r_count;
  assign full  = (r_count == COUNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: a narrow (W=1,D=4) and a wide (W=8,D=3) instance.
// A behavioural model pushes expected state into a queue as each operation is
// driven; the queue is popped and compared once the DUT has taken the edge.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- narrow instance A: WIDTH=1, DEPTH=4 ----------------
  logic       a_reset, a_clr, a_rot, a_sin_r, a_sin_l;
  logic [1:0] a_mode;
  logic [3:0] a_pin, a_pout;
  logic       a_so_r, a_so_l, a_full;
  logic [2:0] a_count;

  univ_shift_reg #(.WIDTH(1), .DEPTH(4)) dut_a (
    .clk(clk), .reset(a_reset), .clr(a_clr), .mode(a_mode), .rot(a_rot),
    .sin_r(a_sin_r), .sin_l(a_sin_l), .pin(a_pin),
    .pout(a_pout), .so_r(a_so_r), .so_l(a_so_l), .count(a_count), .full(a_full)
  );

  // ---------------- wide instance B: WIDTH=8, DEPTH=3 ----------------
  logic        b_reset, b_clr, b_rot;
  logic [1:0]  b_mode;
  logic [7:0]  b_sin_r, b_sin_l, b_so_r, b_so_l;
  logic [23:0] b_pin, b_pout;
  logic [1:0]  b_count;
  logic        b_full;

  univ_shift_reg #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clk(clk), .reset(b_reset), .clr(b_clr), .mode(b_mode), .rot(b_rot),
    .sin_r(b_sin_r), .sin_l(b_sin_l), .pin(b_pin),
    .pout(b_pout), .so_r(b_so_r), .so_l(b_so_l), .count(b_count), .full(b_full)
  );

  typedef struct packed { logic [3:0] pout; logic [2:0] cnt; } exp_a_t;
  typedef struct packed { logic [23:0] pout; logic [1:0] cnt; } exp_b_t;
  typedef struct packed {
    logic c; logic [1:0] md; logic r; logic sr; logic sl; logic [3:0] p;
    logic [3:0] want; logic [2:0] wcnt;
  } op_t;

  exp_a_t q_a[$];
  exp_b_t q_b[$];
  logic [3:0] m_a;
  logic [2:0] m_acnt;
  logic [7:0] m_b [3];
  logic [1:0] m_bcnt;

  // Drive one operation on A, advance the model, queue the expectation.
  task automatic step_a(input logic c, input logic [1:0] md, input logic r,
                        input logic sr, input logic sl, input logic [3:0] p);
    a_clr = c; a_mode = md; a_rot = r; a_sin_r = sr; a_sin_l = sl; a_pin = p;
    if (c) begin
      m_a = 4'b0; m_acnt = 3'd0;
    end else begin
      case (md)
        2'b01: begin m_a = {(r ? m_a[0] : sr), m_a[3:1]}; if (!r && m_acnt < 3'd4) m_acnt++; end
        2'b10: begin m_a = {m_a[2:0], (r ? m_a[3] : sl)}; if (!r && m_acnt < 3'd4) m_acnt++; end
        2'b11: begin m_a = p; m_acnt = 3'd4; end
        default: ;
      endcase
    end
    q_a.push_back(exp_a_t'({m_a, m_acnt}));
    @(posedge clk); #1;
    $display("A clr=%b mode=%b rot=%b sin_r=%b sin_l=%b pin=%b -> pout=%b count=%0d full=%b",
             c, md, r, sr, sl, p, a_pout, a_count, a_full);
    a_clr = 1'b0; a_mode = 2'b00; a_rot = 1'b0;
  endtask

  // Drive one operation on B, advance the model, queue the expectation.
  task automatic step_b(input logic c, input logic [1:0] md, input logic r,
                        input logic [7:0] sr, input logic [7:0] sl, input logic [23:0] p);
    logic [7:0] t0, t2;
    b_clr = c; b_mode = md; b_rot = r; b_sin_r = sr; b_sin_l = sl; b_pin = p;
    t0 = m_b[0]; t2 = m_b[2];
    if (c) begin
      m_b = '{default: 8'h00}; m_bcnt = 2'd0;
    end else begin
      case (md)
        2'b01: begin m_b[0] = m_b[1]; m_b[1] = m_b[2]; m_b[2] = r ? t0 : sr;
                     if (!r && m_bcnt < 2'd3) m_bcnt++; end
        2'b10: begin m_b[2] = m_b[1]; m_b[1] = m_b[0]; m_b[0] = r ? t2 : sl;
                     if (!r && m_bcnt < 2'd3) m_bcnt++; end
        2'b11: begin m_b[0] = p[7:0]; m_b[1] = p[15:8]; m_b[2] = p[23:16]; m_bcnt = 2'd3; end
        default: ;
      endcase
    end
    q_b.push_back(exp_b_t'({m_b[2], m_b[1], m_b[0], m_bcnt}));
    @(posedge clk); #1;
    $display("B clr=%b mode=%b rot=%b sin_r=%h sin_l=%h pin=%h -> pout=%h count=%0d full=%b",
             c, md, r, sr, sl, p, b_pout, b_count, b_full);
    b_clr = 1'b0; b_mode = 2'b00; b_rot = 1'b0;
  endtask

  task automatic clear_a();
    step_a(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0);
    void'(q_a.pop_front());
  endtask

  task automatic test_reset();
    exp_a_t e;
    checks++;
    if (a_pout !== 4'b0 || a_count !== 3'd0 || a_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: pout=%b count=%0d full=%b want 0000/0/0", a_pout, a_count, a_full);
    end
    step_a(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1011);
    e = q_a.pop_front();
    checks++;
    if (a_pout !== e.pout || a_count !== e.cnt) begin
      errors++;
      $display("FAIL reset_preload: pout=%b count=%0d want %b/%0d", a_pout, a_count, e.pout, e.cnt);
    end
    // Assert reset between edges: outputs must clear with no clock.
    #2 a_reset = 1'b1;
    #1;
    checks++;
    if (a_pout !== 4'b0 || a_count !== 3'd0 || a_full !== 1'b0 || a_so_r !== 1'b0 || a_so_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pout=%b count=%0d full=%b want 0000/0/0", a_pout, a_count, a_full);
    end
    a_mode = 2'b11; a_pin = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (a_pout !== 4'b0 || a_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_held: pout=%b count=%0d want 0000/0", a_pout, a_count);
    end
    a_mode = 2'b00;
    #2 a_reset = 1'b0;
    m_a = 4'b0; m_acnt = 3'd0; q_a.delete();
    @(posedge clk); #1;
    step_a(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0110);
    void'(q_a.pop_front());
    for (int k = 0; k < 3; k++) begin
      step_a(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 4'b1001);
      e = q_a.pop_front();
      checks++;
      if (a_pout !== e.pout || a_count !== e.cnt || a_pout !== 4'b0110 || a_count !== 3'd4) begin
        errors++;
        $display("FAIL idle_hold %0d: pout=%b count=%0d want 0110/4", k, a_pout, a_count);
      end
    end
  endtask

  task automatic test_shift_right_fill();
    exp_a_t e;
    op_t ops[5] = '{
      '{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1000, 3'd1},
      '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0100, 3'd2},
      '{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1010, 3'd3},
      '{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1101, 3'd4},
      '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0110, 3'd4}};
    clear_a();
    foreach (ops[k]) begin
      step_a(ops[k].c, ops[k].md, ops[k].r, ops[k].sr, ops[k].sl, ops[k].p);
      e = q_a.pop_front();
      checks++;
      if (a_pout !== e.pout || a_count !== e.cnt || a_full !== (e.cnt == 3'd4) ||
          a_so_r !== e.pout[0] || a_so_l !== e.pout[3] || a_pout !== ops[k].want || a_count !== ops[k].wcnt) begin
        errors++;
        $display("FAIL shr_fill %0d: pout=%b count=%0d full=%b so_r=%b want pout=%b count=%0d",
                 k, a_pout, a_count, a_full, a_so_r, ops[k].want, ops[k].wcnt);
      end
      if (k == 3) begin
        checks++;
        if (a_so_r !== 1'b1 || a_full !== 1'b1) begin
          errors++;
          $display("FAIL shr_full: so_r=%b full=%b want 1/1", a_so_r, a_full);
        end
      end
    end
  endtask

  task automatic test_load_shift_left();
    exp_a_t e;
    op_t ops[2] = '{
      '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 3'd4},
      '{1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 4'h0,    4'b0101, 3'd4}};
    clear_a();
    foreach (ops[k]) begin
      step_a(ops[k].c, ops[k].md, ops[k].r, ops[k].sr, ops[k].sl, ops[k].p);
      e = q_a.pop_front();
      checks++;
      if (a_pout !== e.pout || a_count !== e.cnt || a_so_l !== e.pout[3] ||
          a_pout !== ops[k].want || a_count !== ops[k].wcnt) begin
        errors++;
        $display("FAIL load_shl %0d: pout=%b count=%0d so_l=%b want pout=%b count=%0d",
                 k, a_pout, a_count, a_so_l, ops[k].want, ops[k].wcnt);
      end
    end
  endtask

  task automatic test_rotate();
    exp_a_t e;
    op_t ops[4] = '{
      '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 3'd4},
      '{1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 4'h0,    4'b0100, 3'd4},
      '{1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 4'h0,    4'b1000, 3'd4},
      '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 4'h0,    4'b0001, 3'd4}};
    clear_a();
    foreach (ops[k]) begin
      step_a(ops[k].c, ops[k].md, ops[k].r, ops[k].sr, ops[k].sl, ops[k].p);
      e = q_a.pop_front();
      checks++;
      if (a_pout !== e.pout || a_count !== e.cnt || a_pout !== ops[k].want || a_count !== ops[k].wcnt) begin
        errors++;
        $display("FAIL rotate %0d: pout=%b count=%0d want pout=%b count=%0d",
                 k, a_pout, a_count, ops[k].want, ops[k].wcnt);
      end
    end
    // Rotate from a partial fill must not advance the count.
    clear_a();
    step_a(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0);
    void'(q_a.pop_front());
    step_a(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 4'h0);
    e = q_a.pop_front();
    checks++;
    if (a_pout !== e.pout || a_count !== 3'd1) begin
      errors++;
      $display("FAIL rotate_count: pout=%b count=%0d want %b/1", a_pout, a_count, e.pout);
    end
  endtask

  task automatic test_clear_priority();
    exp_a_t e;
    op_t ops[3] = '{
      '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'hF, 4'b1111, 3'd4},
      '{1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 4'h5, 4'b0000, 3'd0},
      '{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1000, 3'd1}};
    foreach (ops[k]) begin
      step_a(ops[k].c, ops[k].md, ops[k].r, ops[k].sr, ops[k].sl, ops[k].p);
      e = q_a.pop_front();
      checks++;
      if (a_pout !== e.pout || a_count !== e.cnt || a_full !== (e.cnt == 3'd4) ||
          a_pout !== ops[k].want || a_count !== ops[k].wcnt) begin
        errors++;
        $display("FAIL clear_prio %0d: pout=%b count=%0d full=%b want pout=%b count=%0d",
                 k, a_pout, a_count, a_full, ops[k].want, ops[k].wcnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_a_t e;
    logic       c, r, sr, sl;
    logic [1:0] md;
    logic [3:0] p;
    for (int k = 0; k < 40; k++) begin
      c  = ($urandom_range(0, 15) == 0);
      md = 2'($urandom_range(0, 3));
      r  = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      sl = 1'($urandom_range(0, 1));
      p  = 4'($urandom_range(0, 15));
      step_a(c, md, r, sr, sl, p);
      e = q_a.pop_front();
      checks++;
      if (a_pout !== e.pout || a_count !== e.cnt || a_full !== (e.cnt == 3'd4) ||
          a_so_r !== e.pout[0] || a_so_l !== e.pout[3]) begin
        errors++;
        $display("FAIL back_to_back %0d: pout=%b count=%0d full=%b want pout=%b count=%0d",
                 k, a_pout, a_count, a_full, e.pout, e.cnt);
      end
    end
  endtask

  task automatic test_wide();
    exp_b_t e;
    logic [7:0] words[3] = '{8'hA1, 8'hB2, 8'hC3};
    foreach (words[k]) begin
      step_b(1'b0, 2'b01, 1'b0, words[k], 8'h00, 24'h0);
      e = q_b.pop_front();
      checks++;
      if (b_pout !== e.pout || b_count !== e.cnt || b_full !== (e.cnt == 2'd3)) begin
        errors++;
        $display("FAIL wide_shr %0d: pout=%h count=%0d want %h/%0d", k, b_pout, b_count, e.pout, e.cnt);
      end
    end
    checks++;
    if (b_so_r !== 8'hA1 || b_so_l !== 8'hC3 || b_pout !== 24'hC3B2A1 || b_count !== 2'd3 || b_full !== 1'b1) begin
      errors++;
      $display("FAIL wide_fill: so_r=%h so_l=%h pout=%h count=%0d want A1/C3/C3B2A1/3",
               b_so_r, b_so_l, b_pout, b_count);
    end
    step_b(1'b0, 2'b10, 1'b0, 8'h00, 8'h5A, 24'h0);
    e = q_b.pop_front();
    checks++;
    if (b_pout !== e.pout || b_pout !== 24'hB2A15A || b_count !== 2'd3) begin
      errors++;
      $display("FAIL wide_shl: pout=%h count=%0d want B2A15A/3", b_pout, b_count);
    end
    step_b(1'b0, 2'b01, 1'b1, 8'hFF, 8'hFF, 24'h0);
    e = q_b.pop_front();
    checks++;
    if (b_pout !== e.pout || b_pout !== 24'h5AB2A1 || b_count !== 2'd3) begin
      errors++;
      $display("FAIL wide_rot: pout=%h count=%0d want 5AB2A1/3", b_pout, b_count);
    end
    step_b(1'b0, 2'b11, 1'b0, 8'h00, 8'h00, 24'h112233);
    e = q_b.pop_front();
    checks++;
    if (b_pout !== e.pout || b_so_r !== 8'h33 || b_so_l !== 8'h11) begin
      errors++;
      $display("FAIL wide_load: pout=%h so_r=%h so_l=%h want 112233/33/11", b_pout, b_so_r, b_so_l);
    end
    #2 b_reset = 1'b1;
    #1;
    checks++;
    if (b_pout !== 24'h0 || b_count !== 2'd0 || b_full !== 1'b0) begin
      errors++;
      $display("FAIL wide_reset: pout=%h count=%0d full=%b want 0/0/0", b_pout, b_count, b_full);
    end
    #2 b_reset = 1'b0;
    m_b = '{default: 8'h00}; m_bcnt = 2'd0; q_b.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    a_reset = 1'b1; a_clr = 1'b0; a_mode = 2'b00; a_rot = 1'b0;
    a_sin_r = 1'b0; a_sin_l = 1'b0; a_pin = 4'b0;
    b_reset = 1'b1; b_clr = 1'b0; b_mode = 2'b00; b_rot = 1'b0;
    b_sin_r = 8'h0; b_sin_l = 8'h0; b_pin = 24'h0;
    m_a = 4'b0; m_acnt = 3'd0;
    m_b = '{default: 8'h00}; m_bcnt = 2'd0;
    #12;
    a_reset = 1'b0; b_reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_shift_right_fill();
    test_load_shift_left();
    test_rotate();
    test_clear_priority();
    test_back_to_back();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: DEPTH stages of WIDTH bits each. Each clock it can hold, shift right, shift left or parallel-load, with optional rotate and a synchronous clear. A fill counter reports how many stages hold valid shifted-in data. It is the general-purpose successor to the fixed 4-bit serial-in right shifter, used for serial/parallel conversion and delay lines.

## Interface
- WIDTH, default 1: bits per stage; must be >= 1.
- DEPTH, default 4: number of stages; must be >= 2.
- CW, default $clog2(DEPTH+1): fill counter width (derived, not overridden).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; highest synchronous priority.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rot  in  1  in shift modes, substitute the wrapped-around end stage for the serial input.
- sin_r  in  WIDTH  serial input for shift right (enters stage DEPTH-1).
- sin_l  in  WIDTH  serial input for shift left (enters stage 0).
- pin  in  DEPTH*WIDTH  parallel load data; bits [i*WIDTH +: WIDTH] go to stage i.
- pout  out  DEPTH*WIDTH  all stages; stage i on bits [i*WIDTH +: WIDTH].
- so_r  out  WIDTH  stage 0 (right serial out).
- so_l  out  WIDTH  stage DEPTH-1 (left serial out).
- count  out  CW  valid-stage count, 0..DEPTH.
- full  out  1  high when count == DEPTH.

## Operation
- State: stage[0..DEPTH-1] and count. All outputs are direct decodes of registers; there is no combinational path from inputs to outputs.
- reset high: immediately set all stages to 0 and count to 0. This gives pout=0, so_r=0, so_l=0, count=0, full=0. It holds while reset is high.
- Per rising edge with reset low, evaluate in priority order:
  - clr=1: all stages 0, count 0. mode and rot are ignored.
  - mode 00: no change.
  - mode 01, rot=0: stage[DEPTH-1] <= sin_r; stage[i] <= stage[i+1] for i < DEPTH-1. count <= min(count+1, DEPTH).
  - mode 01, rot=1: stage[DEPTH-1] <= stage[0]; the rest is as above. count unchanged.
  - mode 10, rot=0: stage[0] <= sin_l; stage[i] <= stage[i-1] for i > 0. count <= min(count+1, DEPTH).
  - mode 10, rot=1: stage[0] <= stage[DEPTH-1]; the rest is as above. count unchanged.
  - mode 11: stage[i] <= pin slice i; count <= DEPTH. rot is ignored.
- The count saturates at DEPTH and never wraps. Shifting while full keeps count=DEPTH, and the stage shifted out is discarded.
- full = (count == DEPTH), decoded from the registered count.
- Direction changes between consecutive cycles are legal; count still increments on each non-rotate shift.

## Timing
- Latency: one edge from an input to pout/so_r/so_l/count.
- A word entering via sin_r reaches so_r after DEPTH shift-right edges (DEPTH-1 further shifts after entry).
- Assertion of reset acts mid-cycle with no clock needed. Deassertion takes effect from the next rising edge; the first operation happens on that edge.
- A clr and a load on the same edge: clr wins.
- Reset asserted during a shift sequence discards all data; no partial state is kept.

## Test plan
- Reset/idle (WIDTH=1, DEPTH=4): pulse reset between clock edges -> pout=4'b0000, count=0, full=0 at once. mode=00 for 3 cycles -> no change.
- Shift right fill (WIDTH=1, DEPTH=4): sin_r = 1,0,1,1 on 4 edges with mode=01, rot=0 -> pout=4'b1101, so_r=1, count=4, full=1. A 5th shift with sin_r=0 -> pout=4'b0110, count stays 4.
- Load then shift left: mode=11, pin=4'b1010 -> pout=4'b1010, count=4. Then mode=10, sin_l=1 -> pout=4'b0101, so_l=0.
- Rotate: load 4'b1000, then mode=01, rot=1 -> 4'b0100. Then mode=10, rot=1 twice -> 4'b1000, then 4'b0001. count stays 4 throughout.
- Priority and clear: with pout=4'hF, assert clr=1 and mode=11, pin=4'h5 together -> pout=0, count=0. Then one shift right -> count=1, full=0.
- Wide config (WIDTH=8, DEPTH=3): shift right 8'hA1, 8'hB2, 8'hC3 -> so_r=8'hA1, so_l=8'hC3, pout=24'hC3B2A1. Assert reset mid-cycle -> pout=0 immediately.
